// File: rtl/home_scan_ctrl.sv
// home_scan_ctrl: round-robin scanner over NUM_SW maskable sensor slots plus one temperature slot with hysteresis.
// Define HOME_SCAN_LATCH_EN for sample-and-hold actuators; otherwise only the current sensor slot may drive.
module home_scan_ctrl #(
  parameter  int NUM_SW  = 4,
  parameter  int TEMP_W  = 7,
  parameter  int TEMP_LO = 50,
  parameter  int TEMP_HI = 70,
  parameter  int HYST    = 2,
  parameter  int DWELL   = 1,
  localparam int DISP_W  = $clog2(NUM_SW + 3)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [NUM_SW-1:0] i_sw_in,
  input  logic [NUM_SW-1:0] i_sw_mask,
  input  logic [TEMP_W-1:0] i_temp,
  output logic [NUM_SW-1:0] o_act,
  output logic              o_heater,
  output logic              o_cooler,
  output logic [DISP_W-1:0] o_display,
  output logic              o_scan_done
);

  localparam int SLOT_W = $clog2(NUM_SW + 1);
  localparam int DW_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int TW1    = TEMP_W + 1;

  localparam logic [SLOT_W-1:0] TEMP_SLOT = SLOT_W'(NUM_SW);
  localparam logic [DW_W-1:0]   LAST_DW   = DW_W'(DWELL - 1);
  localparam logic [TW1-1:0]    HEAT_ON   = TW1'(TEMP_LO);
  localparam logic [TW1-1:0]    HEAT_OFF  = TW1'(TEMP_LO + HYST);
  localparam logic [TW1-1:0]    COOL_ON   = TW1'(TEMP_HI);
  localparam logic [TW1-1:0]    COOL_OFF  = TW1'(TEMP_HI - HYST);

  logic [SLOT_W-1:0] r_slot;
  logic [DW_W-1:0]   r_dwell;
  logic [NUM_SW-1:0] r_act;
  logic              r_heater;
  logic              r_cooler;
  logic [DISP_W-1:0] r_display;
  logic              r_scan_done;

  logic              w_in_temp;
  logic              w_last_dwell;
  logic [TW1-1:0]    w_temp_x;
  logic [NUM_SW-1:0] w_sel;
  logic [NUM_SW-1:0] w_hit;
  logic [NUM_SW-1:0] w_skip;
  logic [NUM_SW-1:0] w_act_nx;
  logic [SLOT_W-1:0] w_next_slot;
  logic [DISP_W-1:0] w_disp_sens;
  logic [DISP_W-1:0] w_disp_temp;
  logic              w_heat_nx;
  logic              w_cool_nx;

  assign w_in_temp    = (r_slot == TEMP_SLOT);
  assign w_last_dwell = (r_dwell == LAST_DW);
  assign w_temp_x     = {1'b0, i_temp};

  // Live mask gates the current slot: a bit dropped mid-dwell reads as inactive.
  always_comb begin
    w_sel       = '0;
    w_disp_sens = '0;
    for (int k = 0; k < NUM_SW; k++) begin
      w_sel[k] = (r_slot == SLOT_W'(k));
    end
    w_hit = w_sel & i_sw_in & i_sw_mask;
    for (int k = 0; k < NUM_SW; k++) begin
      if (w_hit[k]) w_disp_sens = DISP_W'(k + 1);
    end
  end

  // Next scanned slot above the current one (from index 0 after the temperature slot);
  // the skipped range in between is needed to clear held actuators.
  always_comb begin
    w_next_slot = TEMP_SLOT;
    w_skip      = '0;
    for (int k = NUM_SW - 1; k >= 0; k--) begin
      if (i_sw_mask[k] && (w_in_temp || SLOT_W'(k) > r_slot)) w_next_slot = SLOT_W'(k);
    end
    for (int k = 0; k < NUM_SW; k++) begin
      if ((w_in_temp || SLOT_W'(k) > r_slot) && SLOT_W'(k) < w_next_slot) w_skip[k] = 1'b1;
    end
  end

  always_comb begin
    w_heat_nx = r_heater;
    w_cool_nx = r_cooler;
    if (w_temp_x < HEAT_ON)        w_heat_nx = 1'b1;
    else if (w_temp_x >= HEAT_OFF) w_heat_nx = 1'b0;
    if (w_temp_x > COOL_ON)        w_cool_nx = 1'b1;
    else if (w_temp_x <= COOL_OFF) w_cool_nx = 1'b0;
    if (w_heat_nx)      w_disp_temp = DISP_W'(NUM_SW + 1);
    else if (w_cool_nx) w_disp_temp = DISP_W'(NUM_SW + 2);
    else                w_disp_temp = '0;
  end

`ifdef HOME_SCAN_LATCH_EN
  assign w_act_nx = ((r_act & ~w_sel) | w_hit) & ~(w_last_dwell ? w_skip : '0);
`else
  assign w_act_nx = w_hit;
`endif

  always_ff @(negedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot      <= '0;
      r_dwell     <= '0;
      r_act       <= '0;
      r_heater    <= 1'b0;
      r_cooler    <= 1'b0;
      r_display   <= '0;
      r_scan_done <= 1'b0;
    end else if (!i_en) begin
      r_display   <= '0;
      r_scan_done <= 1'b0;
`ifndef HOME_SCAN_LATCH_EN
      r_act       <= '0;
`endif
    end else begin
      r_scan_done <= w_in_temp && w_last_dwell;
      r_act       <= w_act_nx;
      if (w_in_temp) begin
        r_heater  <= w_heat_nx;
        r_cooler  <= w_cool_nx;
        r_display <= w_disp_temp;
      end else begin
        r_display <= w_disp_sens;
      end
      if (w_last_dwell) begin
        r_dwell <= '0;
        r_slot  <= w_next_slot;
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  assign o_act       = r_act;
  assign o_heater    = r_heater;
  assign o_cooler    = r_cooler;
  assign o_display   = r_display;
  assign o_scan_done = r_scan_done;

endmodule
